// File: rtl/vlc_stream_decoder_if.sv
// Stream, symbol and table-programming signals of the VLC decoder.
// The decoder binds the slave modport; the producer/consumer side uses master.
interface vlc_stream_decoder_if #(
  parameter int WIDTH_IN             = 64,
  parameter int WIDTH_OUT            = 8,
  parameter int MAX_CODE_LENGTH      = 9,
  parameter int LOG2_MAX_CODE_LENGTH = 4
);
  logic                            push;
  logic [WIDTH_IN-1:0]             d;
  logic                            full;
  logic                            half_full;
  logic                            flush;
  logic [WIDTH_OUT-1:0]            q;
  logic                            valid;
  logic                            pop;
  logic                            table_push;
  logic [MAX_CODE_LENGTH-1:0]      table_addr;
  logic [LOG2_MAX_CODE_LENGTH-1:0] table_code_width;
  logic                            table_escape;
  logic [WIDTH_OUT-1:0]            table_data;
  logic                            error;
  logic [31:0]                     symbol_count;

  modport slave (
    input  push, d, flush, pop,
    input  table_push, table_addr, table_code_width, table_escape, table_data,
    output full, half_full, q, valid, error, symbol_count
  );

  modport master (
    output push, d, flush, pop,
    output table_push, table_addr, table_code_width, table_escape, table_data,
    input  full, half_full, q, valid, error, symbol_count
  );
endinterface

// File: rtl/vlc_stream_decoder.sv
// Table-driven variable-length-code decoder with an internal MSB-first bit buffer,
// escape literals, output handshake, tail flush and a sticky invalid-code flag.
module vlc_stream_decoder #(
  parameter int WIDTH_IN             = 64,
  parameter int WIDTH_OUT            = 8,
  parameter int MAX_CODE_LENGTH      = 9,
  parameter int LOG2_MAX_CODE_LENGTH = 4,
  parameter int BUFFER_WIDTH         = 128,
  parameter int FILL_WIDTH           = 8
) (
  input logic                  clk,
  input logic                  rst,
  vlc_stream_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_DECODE = 2'd0,
    ST_ESC    = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  localparam int TBL_DEPTH = 1 << MAX_CODE_LENGTH;
  localparam int ENTRY_W   = 1 + LOG2_MAX_CODE_LENGTH + WIDTH_OUT;

  localparam logic [FILL_WIDTH-1:0] MCL_F    = FILL_WIDTH'(MAX_CODE_LENGTH);
  localparam logic [FILL_WIDTH-1:0] WIN_F    = FILL_WIDTH'(WIDTH_IN);
  localparam logic [FILL_WIDTH-1:0] WOUT_F   = FILL_WIDTH'(WIDTH_OUT);
  localparam logic [FILL_WIDTH-1:0] FULL_F   = FILL_WIDTH'(BUFFER_WIDTH - WIDTH_IN);
  localparam logic [FILL_WIDTH-1:0] HALF_F   = FILL_WIDTH'(BUFFER_WIDTH / 2);
  localparam logic [FILL_WIDTH-1:0] ZERO_F   = {FILL_WIDTH{1'b0}};
  localparam logic [LOG2_MAX_CODE_LENGTH-1:0] ZERO_W = {LOG2_MAX_CODE_LENGTH{1'b0}};

  logic [ENTRY_W-1:0] table_mem [TBL_DEPTH];

  state_t                     state_q, state_d;
  logic [BUFFER_WIDTH-1:0]    buf_q, buf_d;
  logic [FILL_WIDTH-1:0]      fill_q, fill_d;
  logic                       flushing_q, flushing_d;
  logic                       valid_q, valid_d;
  logic [WIDTH_OUT-1:0]       sym_q, sym_d;
  logic                       error_q, error_d;
  logic [31:0]                count_q, count_d;
  logic                       full_q, full_d;
  logic                       half_q, half_d;

  logic [ENTRY_W-1:0]              entry_s;
  logic                            ent_escape_s;
  logic [LOG2_MAX_CODE_LENGTH-1:0] ent_width_s;
  logic [FILL_WIDTH-1:0]           ent_width_f_s;
  logic [WIDTH_OUT-1:0]            ent_data_s;
  logic                            slot_free_s;
  logic                            decode_fire_s;
  logic                            tail_discard_s;
  logic                            push_ok_s;
  logic [FILL_WIDTH-1:0]           consume_s;
  logic [FILL_WIDTH-1:0]           remain_s;

  // Table write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (bus.table_push) begin
      table_mem[bus.table_addr] <= {bus.table_escape, bus.table_code_width, bus.table_data};
    end
  end

  assign entry_s       = table_mem[buf_q[BUFFER_WIDTH-1 -: MAX_CODE_LENGTH]];
  assign ent_escape_s  = entry_s[ENTRY_W-1];
  assign ent_width_s   = entry_s[WIDTH_OUT +: LOG2_MAX_CODE_LENGTH];
  assign ent_data_s    = entry_s[WIDTH_OUT-1:0];
  assign ent_width_f_s = FILL_WIDTH'(ent_width_s);

  assign slot_free_s    = ~valid_q | bus.pop;
  assign push_ok_s      = bus.push & ~full_q;
  assign decode_fire_s  = slot_free_s & ~bus.table_push &
                          ((fill_q >= MCL_F) | (flushing_q & (fill_q != ZERO_F)));
  // Only reachable while flushing: the stream tail is shorter than any code that matches it
  assign tail_discard_s = (fill_q < MCL_F) & ((ent_width_s == ZERO_W) | (ent_width_f_s > fill_q));

  // FSM next state, output slot and bit-consume amount
  always_comb begin
    state_d   = state_q;
    consume_s = ZERO_F;
    sym_d     = sym_q;
    valid_d   = valid_q & ~bus.pop;
    error_d   = error_q;
    case (state_q)
      ST_DECODE: begin
        if (decode_fire_s) begin
          if (tail_discard_s) begin
            consume_s = fill_q;
          end else if (ent_width_s == ZERO_W) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else if (ent_escape_s) begin
            consume_s = ent_width_f_s;
            state_d   = ST_ESC;
          end else begin
            consume_s = ent_width_f_s;
            sym_d     = ent_data_s;
            valid_d   = 1'b1;
          end
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_ESC: begin
        if (slot_free_s && (fill_q >= WOUT_F)) begin
          sym_d     = buf_q[BUFFER_WIDTH-1 -: WIDTH_OUT];
          valid_d   = 1'b1;
          consume_s = WOUT_F;
          state_d   = ST_DECODE;
        end else begin
          state_d = ST_ESC;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_DECODE;
      end
    endcase
  end

  // Bit buffer: consume from the top, then append the new word just below what remains
  always_comb begin
    remain_s = fill_q - consume_s;
    if (push_ok_s) begin
      fill_d = remain_s + WIN_F;
      buf_d  = (buf_q << consume_s) |
               ({bus.d, {(BUFFER_WIDTH-WIDTH_IN){1'b0}}} >> remain_s);
    end else begin
      fill_d = remain_s;
      buf_d  = buf_q << consume_s;
    end
    if (fill_d == ZERO_F) begin
      flushing_d = 1'b0;
    end else if (bus.flush) begin
      flushing_d = 1'b1;
    end else if (push_ok_s) begin
      flushing_d = 1'b0;
    end else begin
      flushing_d = flushing_q;
    end
    if (valid_q && bus.pop) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    full_d = fill_d > FULL_F;
    half_d = fill_d >= HALF_F;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_DECODE;
      buf_q      <= {BUFFER_WIDTH{1'b0}};
      fill_q     <= ZERO_F;
      flushing_q <= 1'b0;
      valid_q    <= 1'b0;
      sym_q      <= {WIDTH_OUT{1'b0}};
      error_q    <= 1'b0;
      count_q    <= 32'd0;
      full_q     <= 1'b0;
      half_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      flushing_q <= flushing_d;
      valid_q    <= valid_d;
      sym_q      <= sym_d;
      error_q    <= error_d;
      count_q    <= count_d;
      full_q     <= full_d;
      half_q     <= half_d;
    end
  end

  assign bus.q            = sym_q;
  assign bus.valid        = valid_q;
  assign bus.error        = error_q;
  assign bus.symbol_count = count_q;
  assign bus.full         = full_q;
  assign bus.half_full    = half_q;

endmodule
